// File: rtl/hex_digit_scanner.sv
// hex_digit_scanner: time-multiplexes a NUM_DIGITS-digit hex value onto one
// shared 7-segment decoder. Each slot drives one nibble plus a one-hot digit
// enable. A shadow register (active) only reloads at frame boundaries so the
// display never tears. A dark gap at the start of every slot suppresses ghosting.
// Build option: define HEX_SCAN_LZ_BLANK_EN for leading-zero blanking.
module hex_digit_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE_W = 10,
  parameter int GAP_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  output logic [3:0]              nibble,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    blank,
  output logic                    frame_start
);

  localparam int VALUE_W = 4 * NUM_DIGITS;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRESCALE_W-1:0] CNT_MAX  = '1;
  localparam logic [PRESCALE_W-1:0] GAP_LAST =
    (GAP_CYCLES > 0) ? PRESCALE_W'(GAP_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    SHOW
  } state_t;

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VALUE_W-1:0]    pending_q, pending_d;
  logic [VALUE_W-1:0]    active_q, active_d;
  logic [3:0]            nibble_q, nibble_d;
  logic [NUM_DIGITS-1:0] digitSel_q, digitSel_d;
  logic                  blank_q, blank_d;
  logic                  frameStart_q, frameStart_d;
  logic [NUM_DIGITS-1:0] keepMask;
`ifdef HEX_SCAN_LZ_BLANK_EN
  logic                  seenNonZero;
`endif

  // The load buffer captures value on every strobe, whatever the scan is doing.
  always_comb begin
    pending_d = load ? value : pending_q;
  end

  // Slot/frame sequencing: counter, digit index, state and the frame-boundary shadow reload.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    active_d     = active_q;
    frameStart_d = 1'b0;
    if (!ena) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == IDLE || (cnt_q == CNT_MAX && idx_q == IDX_LAST)) begin
      if (GAP_CYCLES > 0) state_d = GAP;
      else                state_d = SHOW;
      cnt_d        = '0;
      idx_d        = '0;
      active_d     = load ? value : pending_q;
      frameStart_d = 1'b1;
    end else if (cnt_q == CNT_MAX) begin
      if (GAP_CYCLES > 0) state_d = GAP;
      else                state_d = SHOW;
      cnt_d = '0;
      idx_d = idx_q + IDX_W'(1);
    end else begin
      if (state_q == GAP && cnt_q == GAP_LAST) state_d = SHOW;
      cnt_d = cnt_q + PRESCALE_W'(1);
    end
  end

  // Output decode from the next state so the output registers line up with the state register.
  always_comb begin
    nibble_d   = nibble_q;
    digitSel_d = '0;
    keepMask   = '1;
`ifdef HEX_SCAN_LZ_BLANK_EN
    seenNonZero = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seenNonZero = seenNonZero | (|active_d[4*i +: 4]);
      keepMask[i] = seenNonZero || (i == 0);
    end
`endif
    if (state_d != IDLE) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_d == IDX_W'(i)) nibble_d = active_d[4*i +: 4];
      end
    end
    if (state_d == SHOW) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digitSel_d[i] = (idx_d == IDX_W'(i)) && keepMask[i];
      end
    end
    blank_d = ~|digitSel_d;
  end

  // All state and outputs are registered; reset takes effect immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      pending_q    <= '0;
      active_q     <= '0;
      nibble_q     <= '0;
      digitSel_q   <= '0;
      blank_q      <= 1'b1;
      frameStart_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      active_q     <= active_d;
      nibble_q     <= nibble_d;
      digitSel_q   <= digitSel_d;
      blank_q      <= blank_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign nibble      = nibble_q;
  assign digit_sel   = digitSel_q;
  assign blank       = blank_q;
  assign frame_start = frameStart_q;

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Testbench for hex_digit_scanner (NUM_DIGITS=4, PRESCALE_W=4, GAP_CYCLES=2).
// Expected outputs come from a frame-position reference model and are queued
// at each clock edge; an independent monitor pops and compares on the falling edge.
module tb_hex_digit_scanner;

  localparam int ND    = 4;
  localparam int PW    = 4;
  localparam int GAP   = 2;
  localparam int SLOT  = 1 << PW;
  localparam int FRAME = ND * SLOT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ena = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    nibble;
  logic [ND-1:0] digit_sel;
  logic          blank;
  logic          frame_start;

  typedef struct {
    logic [3:0]    nib;
    logic [ND-1:0] sel;
    logic          blk;
    logic          fs;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   total = 0;
  int   bad = 0;

  // Reference model state: position within the current frame and the two value buffers.
  bit          running = 1'b0;
  int          pos = 0;
  logic [15:0] mPending = '0;
  logic [15:0] mActive = '0;
  logic [3:0]  mNibble = '0;

  hex_digit_scanner #(
    .NUM_DIGITS(ND),
    .PRESCALE_W(PW),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .value(value),
    .load(load),
    .nibble(nibble),
    .digit_sel(digit_sel),
    .blank(blank),
    .frame_start(frame_start)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance the model by one clock edge given the inputs presented at that edge.
  task automatic modelStep(input bit e, input bit ld, input logic [15:0] v, output exp_t x);
    int slot;
    int off;
    bit lit;
`ifdef HEX_SCAN_LZ_BLANK_EN
    int msd;
`endif
    x.fs = 1'b0;
    if (!e) begin
      running = 1'b0;
      x.sel   = '0;
      x.blk   = 1'b1;
      x.nib   = mNibble;
    end else begin
      if (!running || pos == FRAME - 1) begin
        pos     = 0;
        mActive = ld ? v : mPending;
        x.fs    = 1'b1;
      end else begin
        pos++;
      end
      running = 1'b1;
      slot    = pos / SLOT;
      off     = pos % SLOT;
      mNibble = 4'((mActive >> (4 * slot)) & 16'hF);
      lit     = (off >= GAP);
`ifdef HEX_SCAN_LZ_BLANK_EN
      msd = 0;
      for (int k = 0; k < ND; k++) begin
        if (((mActive >> (4 * k)) & 16'hF) != 0) msd = k;
      end
      if (slot > msd) lit = 1'b0;
`endif
      x.nib = mNibble;
      x.sel = lit ? ND'(1 << slot) : '0;
      x.blk = !lit;
    end
    if (ld) mPending = v;
  endtask

  // Drive one cycle of inputs, queue the model's expectation, return just after the falling edge.
  task automatic applyStimulus(input bit e, input bit ld, input logic [15:0] v);
    exp_t x;
    ena   = e;
    load  = ld;
    value = v;
    @(posedge clk);
    modelStep(e, ld, v, x);
    expQ.push_back(x);
    @(negedge clk);
    #1;
  endtask

  // Scan with ena=1, strobing load whenever the model sits at frame position atPos.
  task automatic runWithLoad(input int cycles, input int atPos, input logic [15:0] v);
    for (int c = 0; c < cycles; c++) begin
      if (running && pos == atPos) applyStimulus(1'b1, 1'b1, v);
      else                         applyStimulus(1'b1, 1'b0, 16'h0000);
    end
  endtask

  // Scan until the model reaches frame position target, with a cycle budget.
  task automatic runUntilPos(input int target);
    int budget = 4 * FRAME;
    while (!(running && pos == target) && budget > 0) begin
      applyStimulus(1'b1, 1'b0, 16'h0000);
      budget--;
    end
    checkOutput("reach_pos_budget", 32'(budget > 0), 32'd1);
  endtask

  // Assert reset between edges and confirm outputs clear without any clock edge.
  task automatic pulseReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_digit_sel", 32'(digit_sel), 32'h0);
    checkOutput("rst_blank", 32'(blank), 32'h1);
    checkOutput("rst_nibble", 32'(nibble), 32'h0);
    checkOutput("rst_frame_start", 32'(frame_start), 32'h0);
    repeat (2) @(negedge clk);
    #1;
    rst_n    = 1'b1;
    running  = 1'b0;
    pos      = 0;
    mPending = '0;
    mActive  = '0;
    mNibble  = '0;
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation on every falling edge.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monExp = expQ.pop_front();
      checkOutput("nibble", 32'(nibble), 32'(monExp.nib));
      checkOutput("digit_sel", 32'(digit_sel), 32'(monExp.sel));
      checkOutput("blank", 32'(blank), 32'(monExp.blk));
      checkOutput("frame_start", 32'(frame_start), 32'(monExp.fs));
    end
  end

  // Guard against a stuck run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Main stimulus sequence: directed scenarios, then randomized traffic.
  initial begin
    logic [15:0] rv;
    bit          re;
    bit          rl;
    #2;
    pulseReset();

    $display("[TB] basic scan of 12A4");
    applyStimulus(1'b0, 1'b1, 16'h12A4);
    runWithLoad(2 * FRAME, -1, 16'h0000);

    $display("[TB] mid-frame load of BEEF during digit 1");
    runWithLoad(2 * FRAME, SLOT + 4, 16'hBEEF);

    $display("[TB] boundary load of 5678");
    runWithLoad(FRAME + 8, FRAME - 1, 16'h5678);
    runWithLoad(FRAME, -1, 16'h0000);

    $display("[TB] enable drop during digit 2");
    runUntilPos(2 * SLOT + 6);
    repeat (5) applyStimulus(1'b0, 1'b0, 16'h0000);
    runWithLoad(FRAME + 16, -1, 16'h0000);

    $display("[TB] leading-zero values");
    runWithLoad(FRAME + 4, FRAME - 1, 16'h0030);
    runWithLoad(FRAME + 4, FRAME - 1, 16'h0000);

    $display("[TB] reset during SHOW");
    runUntilPos(SLOT + 7);
    pulseReset();
    runWithLoad(FRAME, -1, 16'h0000);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 1500; c++) begin
      re = ($urandom_range(0, 99) != 0);
      rl = ($urandom_range(0, 19) == 0);
      rv = 16'($urandom);
      rv = rv >> (4 * $urandom_range(0, 4));
      applyStimulus(re, rl, rv);
    end
    applyStimulus(1'b1, 1'b0, 16'h0000);

    @(negedge clk);
    #1;
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
